// File: rtl/frame_mode_pkg.sv
// Shared types and mode constants for the frame-gated option mux controller.
// Modes 0..6 are processing modes; 7 forces black.
package frame_mode_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        PENDING,
        BLANK
    } fms_state_t;

    localparam logic [2:0] MODE_PASS  = 3'd0;
    localparam logic [2:0] MODE_YCBCR = 3'd1;
    localparam logic [2:0] MODE_BLACK = 3'd7;
    localparam logic [2:0] AUTO_LAST  = 3'd6;

    // Auto-demo successor: black is never entered and 6 wraps to pass-through.
    function automatic logic [2:0] nextAutoMode(input logic [2:0] mode);
        if (mode == MODE_BLACK || mode == AUTO_LAST)
            return MODE_PASS;
        return mode + MODE_YCBCR;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Switch-word debouncer: a new value is accepted once it has been seen on
// DEBOUNCE_CYCLES consecutive clock edges.
module sw_debouncer #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iRaw,
    output logic [WIDTH-1:0] oStable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    count;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            candidate <= '0;
            count     <= '0;
            oStable   <= '0;
        end else begin
            candidate <= iRaw;
            if (iRaw != candidate) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // Counter parks here; stable keeps tracking the settled word.
                oStable <= candidate;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_mode_sequencer.sv
// Frame-gated processing-mode sequencer with post-switch blanking and an
// auto-demo stepper, driving the image processor's mode select.
module frame_mode_sequencer
    import frame_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 60,
    parameter int BLANK_FRAMES    = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [4:0] iSw,
    input  logic       iAuto,
    input  logic       iFrameValid,
    output logic [2:0] oMode,
    output logic [1:0] oDebugSel,
    output logic       oBlank,
    output logic       oSwitchPulse
);

    localparam int AW = $clog2(AUTO_FRAMES) + 1;
    localparam int BW = $clog2(BLANK_FRAMES) + 1;
    localparam logic [AW-1:0] AUTO_CNT_LAST = AW'(AUTO_FRAMES - 1);
    localparam logic [BW-1:0] BLANK_CNT_LAST =
        BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    logic [4:0]    stable;
    logic          fvQ;
    logic          fe;
    logic [AW-1:0] autoCnt;
    logic [2:0]    autoReq;
    logic [2:0]    req;
    logic [2:0]    target;
    logic [BW-1:0] blankCnt;
    fms_state_t    state;

    sw_debouncer #(
        .WIDTH           (5),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) uDebouncer (
        .iClk    (iClk),
        .iRst    (iRst),
        .iRaw    (iSw),
        .oStable (stable)
    );

    assign oDebugSel = stable[4:3];
    assign fe        = fvQ & ~iFrameValid;
    assign req       = iAuto ? autoReq : stable[2:0];

    // Outside auto mode the auto request shadows the committed mode, so
    // enabling auto never triggers a spurious switch.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fvQ     <= 1'b0;
            autoCnt <= '0;
            autoReq <= MODE_PASS;
        end else begin
            fvQ <= iFrameValid;
            if (!iAuto) begin
                autoCnt <= '0;
                autoReq <= oMode;
            end else if (fe) begin
                if (autoCnt == AUTO_CNT_LAST) begin
                    autoCnt <= '0;
                    autoReq <= nextAutoMode(oMode);
                end else begin
                    autoCnt <= autoCnt + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= ACTIVE;
            target       <= MODE_PASS;
            oMode        <= MODE_PASS;
            oBlank       <= 1'b0;
            oSwitchPulse <= 1'b0;
            blankCnt     <= '0;
        end else begin
            oSwitchPulse <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (req != oMode) begin
                        target <= req;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (fe) begin
                        oMode        <= target;
                        oSwitchPulse <= 1'b1;
                        blankCnt     <= '0;
                        if (BLANK_FRAMES > 0) begin
                            oBlank <= 1'b1;
                            state  <= BLANK;
                        end else begin
                            state <= ACTIVE;
                        end
                    end else if (req == oMode) begin
                        state <= ACTIVE;
                    end else begin
                        target <= req;
                    end
                end
                BLANK: begin
                    if (fe) begin
                        if (blankCnt == BLANK_CNT_LAST) begin
                            blankCnt <= '0;
                            oBlank   <= 1'b0;
                            state    <= ACTIVE;
                        end else begin
                            blankCnt <= blankCnt + BW'(1);
                        end
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule
